// File: rtl/mem_port_arbiter_pkg.sv
// Shared types and defaults for the unified-memory port arbiter.
package mem_port_arbiter_pkg;

    localparam int unsigned DSTREAK_MAX_DEFAULT = 4;

    typedef enum logic {
        ARB       = 1'b0,
        WAIT_RESP = 1'b1
    } arb_state_e;

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_IF   = 2'd1,
        OWN_DM   = 2'd2
    } mem_owner_e;

endpackage : mem_port_arbiter_pkg

// File: rtl/mem_port_arbiter.sv
// Arbitrates the IF and MEM stages onto one single-port memory with one
// outstanding transaction; responses are routed back to the issuing stage.
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int unsigned ADDR_W      = 32,
    parameter int unsigned DATA_W      = 32,
    parameter int unsigned DSTREAK_MAX = DSTREAK_MAX_DEFAULT
) (
    input  logic                clk,
    input  logic                rst_n,

    input  logic                if_req_i,
    input  logic [ADDR_W-1:0]   if_addr_i,
    output logic                if_gnt_o,
    output logic                if_rvalid_o,
    output logic [DATA_W-1:0]   if_rdata_o,

    input  logic                dm_req_i,
    input  logic                dm_we_i,
    input  logic [DATA_W/8-1:0] dm_be_i,
    input  logic [ADDR_W-1:0]   dm_addr_i,
    input  logic [DATA_W-1:0]   dm_wdata_i,
    output logic                dm_gnt_o,
    output logic                dm_rvalid_o,
    output logic [DATA_W-1:0]   dm_rdata_o,

    output logic                mem_req_o,
    output logic                mem_we_o,
    output logic [DATA_W/8-1:0] mem_be_o,
    output logic [ADDR_W-1:0]   mem_addr_o,
    output logic [DATA_W-1:0]   mem_wdata_o,
    input  logic                mem_gnt_i,
    input  logic                mem_rvalid_i,
    input  logic [DATA_W-1:0]   mem_rdata_i,

    output logic                busy_o
);

    localparam int unsigned DS_W = $clog2(DSTREAK_MAX + 1);
    localparam logic [DS_W-1:0] DS_MAX = DS_W'(DSTREAK_MAX);

    arb_state_e      r_state;
    mem_owner_e      r_owner;
    mem_owner_e      r_lock_owner;
    logic            r_lock_valid;
    logic [DS_W-1:0] r_dstreak;

    mem_owner_e      w_sel;
    logic            w_arb;
    logic            w_resp;

    assign w_arb  = (r_state == ARB);
    assign busy_o = (r_state == WAIT_RESP);

    // Requester selection: a held lock wins, else data unless it has starved fetch.
    always_comb begin
        w_sel = OWN_NONE;
        if (r_lock_valid) begin
            w_sel = r_lock_owner;
        end else if (dm_req_i && (r_dstreak < DS_MAX)) begin
            w_sel = OWN_DM;
        end else if (if_req_i) begin
            w_sel = OWN_IF;
        end else if (dm_req_i) begin
            w_sel = OWN_DM;
        end
    end

    // Memory request mux and same-cycle grant pass-through.
    always_comb begin
        mem_req_o   = 1'b0;
        mem_we_o    = 1'b0;
        mem_be_o    = '0;
        mem_addr_o  = '0;
        mem_wdata_o = '0;
        if_gnt_o    = 1'b0;
        dm_gnt_o    = 1'b0;
        if (w_arb) begin
            case (w_sel)
                OWN_IF: begin
                    mem_req_o  = 1'b1;
                    mem_be_o   = '1;
                    mem_addr_o = if_addr_i;
                    if_gnt_o   = mem_gnt_i;
                end
                OWN_DM: begin
                    mem_req_o   = 1'b1;
                    mem_we_o    = dm_we_i;
                    mem_be_o    = dm_be_i;
                    mem_addr_o  = dm_addr_i;
                    mem_wdata_o = dm_wdata_i;
                    dm_gnt_o    = mem_gnt_i;
                end
                default: ;
            endcase
        end
    end

    // Response routing to the owner; the non-owner sees zero data.
    always_comb begin
        w_resp      = busy_o && mem_rvalid_i;
        if_rvalid_o = w_resp && (r_owner == OWN_IF);
        dm_rvalid_o = w_resp && (r_owner == OWN_DM);
        if_rdata_o  = if_rvalid_o ? mem_rdata_i : '0;
        dm_rdata_o  = dm_rvalid_o ? mem_rdata_i : '0;
    end

    // Transaction FSM, selection lock and data-streak counter.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state      <= ARB;
            r_owner      <= OWN_NONE;
            r_lock_owner <= OWN_NONE;
            r_lock_valid <= 1'b0;
            r_dstreak    <= '0;
        end else begin
            case (r_state)
                ARB: begin
                    if (w_sel != OWN_NONE) begin
                        if (mem_gnt_i) begin
                            r_state      <= WAIT_RESP;
                            r_owner      <= w_sel;
                            r_lock_valid <= 1'b0;
                            if ((w_sel == OWN_DM) && if_req_i) begin
                                if (r_dstreak != DS_MAX) begin
                                    r_dstreak <= r_dstreak + DS_W'(1);
                                end
                            end else begin
                                r_dstreak <= '0;
                            end
                        end else begin
                            r_lock_owner <= w_sel;
                            r_lock_valid <= 1'b1;
                        end
                    end
                end
                WAIT_RESP: begin
                    if (mem_rvalid_i) begin
                        r_owner <= OWN_NONE;
                        r_state <= ARB;
                    end
                end
                default: r_state <= ARB;
            endcase
        end
    end

endmodule : mem_port_arbiter

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: requester agents and a memory model
// drive the DUT; a negedge monitor checks arbitration and response routing.
module tb_mem_port_arbiter;

    localparam int unsigned DSTREAK = 4;

    typedef struct {
        logic        we;
        logic [3:0]  be;
        logic [31:0] addr;
        logic [31:0] wdata;
    } dreq_t;

    typedef struct {
        logic        st;
        logic [31:0] d;
    } exp_t;

    typedef struct {
        logic [1:0]  own;
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
    } glog_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        if_req_i, if_gnt_o, if_rvalid_o;
    logic [31:0] if_addr_i, if_rdata_o;
    logic        dm_req_i, dm_we_i, dm_gnt_o, dm_rvalid_o;
    logic [3:0]  dm_be_i;
    logic [31:0] dm_addr_i, dm_wdata_i, dm_rdata_o;
    logic        mem_req_o, mem_we_o, mem_gnt_i, mem_rvalid_i;
    logic [3:0]  mem_be_o;
    logic [31:0] mem_addr_o, mem_wdata_o, mem_rdata_i;
    logic        busy_o;

    mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .DSTREAK_MAX(DSTREAK)) dut (
        .clk(clk), .rst_n(rst_n),
        .if_req_i(if_req_i), .if_addr_i(if_addr_i), .if_gnt_o(if_gnt_o),
        .if_rvalid_o(if_rvalid_o), .if_rdata_o(if_rdata_o),
        .dm_req_i(dm_req_i), .dm_we_i(dm_we_i), .dm_be_i(dm_be_i),
        .dm_addr_i(dm_addr_i), .dm_wdata_i(dm_wdata_i), .dm_gnt_o(dm_gnt_o),
        .dm_rvalid_o(dm_rvalid_o), .dm_rdata_o(dm_rdata_o),
        .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_be_o(mem_be_o),
        .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o),
        .mem_gnt_i(mem_gnt_i), .mem_rvalid_i(mem_rvalid_i), .mem_rdata_i(mem_rdata_i),
        .busy_o(busy_o)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Scoreboard queues and reference memory (requester view).
    exp_t        exp_if[$];
    exp_t        exp_dm[$];
    logic [31:0] ref_mem[16];

    // Memory model state (memory-port view).
    logic [31:0] mm_mem[16];
    bit          mm_pend;
    int          mm_cnt;
    int          mm_hold;
    logic [31:0] mm_rdata;

    // Agent stimulus and knobs.
    logic [31:0] if_todo[$];
    dreq_t       dm_todo[$];
    glog_t       g_log[$];
    int          k_p_if, k_p_dm, k_p_gnt, k_lat_min, k_lat_max;
    bit          k_force_rv;

    // Outputs sampled by the driver at the last negedge.
    logic        o_if_gnt, o_dm_gnt, o_if_rv, o_dm_rv, o_busy, o_mreq, o_mwe, o_macc;
    logic [3:0]  o_mbe;
    logic [31:0] o_if_rd, o_maddr, o_mwd;

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", nm, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd,
                                          input logic [3:0] be);
        logic [31:0] r;
        r = old;
        for (int b = 0; b < 4; b++) if (be[b]) r[8*b +: 8] = wd[8*b +: 8];
        return r;
    endfunction

    function automatic logic [31:0] rand_addr();
        return 32'($urandom_range(15)) << 2;
    endfunction

    task automatic sample();
        o_if_gnt = if_gnt_o;   o_dm_gnt = dm_gnt_o;
        o_if_rv  = if_rvalid_o; o_dm_rv = dm_rvalid_o;
        o_if_rd  = if_rdata_o;  o_busy  = busy_o;
        o_mreq   = mem_req_o;   o_mwe   = mem_we_o;   o_mbe = mem_be_o;
        o_maddr  = mem_addr_o;  o_mwd   = mem_wdata_o;
        o_macc   = mem_req_o && mem_gnt_i;
    endtask

    // One bus cycle: consume last cycle's handshakes, drive new inputs, sample.
    task automatic cycle();
        dreq_t d;
        @(posedge clk); #1;
        if (o_if_gnt) begin
            exp_if.push_back('{st: 1'b0, d: ref_mem[if_addr_i[5:2]]});
            g_log.push_back('{own: 2'd1, we: o_mwe, addr: o_maddr, wdata: o_mwd});
            if_req_i = 1'b0;
        end
        if (o_dm_gnt) begin
            if (dm_we_i) ref_mem[dm_addr_i[5:2]] = merge(ref_mem[dm_addr_i[5:2]], dm_wdata_i, dm_be_i);
            exp_dm.push_back('{st: dm_we_i, d: ref_mem[dm_addr_i[5:2]]});
            g_log.push_back('{own: 2'd2, we: o_mwe, addr: o_maddr, wdata: o_mwd});
            dm_req_i = 1'b0;
        end
        if (o_macc) begin
            mm_pend  = 1'b1;
            mm_cnt   = int'($urandom_range(k_lat_max, k_lat_min)) - 1;
            mm_rdata = mm_mem[o_maddr[5:2]];
            if (o_mwe) mm_mem[o_maddr[5:2]] = merge(mm_mem[o_maddr[5:2]], o_mwd, o_mbe);
        end
        mem_rvalid_i = 1'b0;
        mem_rdata_i  = $urandom;
        if (k_force_rv) begin
            mem_rvalid_i = 1'b1;
            k_force_rv   = 1'b0;
        end else if (mm_pend) begin
            if (mm_cnt == 0) begin
                mem_rvalid_i = 1'b1;
                mem_rdata_i  = mm_rdata;
                mm_pend      = 1'b0;
            end else begin
                mm_cnt--;
            end
        end
        mem_gnt_i = (mm_hold > 0) ? 1'b0 : (int'($urandom_range(99)) < k_p_gnt);
        if (mm_hold > 0) mm_hold--;
        if (!if_req_i) begin
            if (if_todo.size() > 0) begin
                if_req_i = 1'b1; if_addr_i = if_todo.pop_front();
            end else if (int'($urandom_range(99)) < k_p_if) begin
                if_req_i = 1'b1; if_addr_i = rand_addr();
            end
        end
        if (!dm_req_i) begin
            if (dm_todo.size() > 0) begin
                d = dm_todo.pop_front();
                dm_req_i = 1'b1; dm_we_i = d.we; dm_be_i = d.be; dm_addr_i = d.addr; dm_wdata_i = d.wdata;
            end else if (int'($urandom_range(99)) < k_p_dm) begin
                dm_req_i = 1'b1; dm_we_i = $urandom_range(1) == 1; dm_be_i = 4'($urandom_range(15, 1));
                dm_addr_i = rand_addr(); dm_wdata_i = $urandom;
            end
        end
        @(negedge clk);
        sample();
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        rst_n = 1'b0; if_req_i = 1'b0; dm_req_i = 1'b0;
        mem_gnt_i = 1'b0; mem_rvalid_i = 1'b0; mem_rdata_i = '0;
        if_todo.delete(); dm_todo.delete(); exp_if.delete(); exp_dm.delete(); g_log.delete();
        mm_pend = 1'b0; mm_hold = 0; k_force_rv = 1'b0;
        k_p_if = 0; k_p_dm = 0; k_p_gnt = 100; k_lat_min = 1; k_lat_max = 1;
        @(posedge clk); @(posedge clk);
        @(negedge clk);
        sample();
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic run_until_log(input int n, input int budget, input string nm);
        for (int i = 0; i < budget && g_log.size() < n; i++) cycle();
        chk(nm, 32'(g_log.size() >= n), 32'd1);
    endtask

    task automatic drain(input string nm);
        bit idle;
        k_p_if = 0; k_p_dm = 0;
        idle = 1'b0;
        for (int i = 0; i < 300 && !idle; i++) begin
            cycle();
            idle = !if_req_i && !dm_req_i && !mm_pend && !o_busy && if_todo.size() == 0 &&
                   dm_todo.size() == 0 && exp_if.size() == 0 && exp_dm.size() == 0;
        end
        cycle();
        chk(nm, 32'(idle && exp_if.size() == 0 && exp_dm.size() == 0), 32'd1);
    endtask

    // Monitor: spec-level arbitration model and response scoreboard.
    logic [1:0] m_pick, m_owner;
    bit         m_out;
    int         m_streak;
    initial begin : monitor
        exp_t e;
        m_pick = 2'd0; m_owner = 2'd0; m_out = 1'b0; m_streak = 0;
        forever begin
            @(negedge clk);
            if (rst_n !== 1'b1) begin
                m_pick = 2'd0; m_out = 1'b0; m_streak = 0;
            end else if (m_out) begin
                chk("busy_wait", 32'(busy_o), 32'd1);
                chk("gnt_in_wait", 32'({if_gnt_o, dm_gnt_o}), 32'd0);
                chk("mreq_in_wait", 32'(mem_req_o), 32'd0);
                chk("if_rvalid", 32'(if_rvalid_o), 32'(mem_rvalid_i && m_owner == 2'd1));
                chk("dm_rvalid", 32'(dm_rvalid_o), 32'(mem_rvalid_i && m_owner == 2'd2));
                if (mem_rvalid_i) begin
                    if (m_owner == 2'd1) begin
                        chk("dm_rdata_nonowner", dm_rdata_o, 32'd0);
                        chk("if_pending_cnt", 32'(exp_if.size()), 32'd1);
                        if (exp_if.size() > 0) begin
                            e = exp_if.pop_front();
                            chk("if_rdata", if_rdata_o, e.d);
                        end
                    end else begin
                        chk("if_rdata_nonowner", if_rdata_o, 32'd0);
                        chk("dm_pending_cnt", 32'(exp_dm.size()), 32'd1);
                        if (exp_dm.size() > 0) begin
                            e = exp_dm.pop_front();
                            if (!e.st) chk("dm_rdata", dm_rdata_o, e.d);
                        end
                    end
                    m_out = 1'b0;
                end
            end else begin
                chk("busy_arb", 32'(busy_o), 32'd0);
                chk("rvalid_in_arb", 32'({if_rvalid_o, dm_rvalid_o}), 32'd0);
                if (m_pick == 2'd1) assert (if_req_i) else $error("protocol: fetch request withdrawn before grant");
                if (m_pick == 2'd2) assert (dm_req_i) else $error("protocol: data request withdrawn before grant");
                if (m_pick == 2'd0 && (if_req_i || dm_req_i))
                    m_pick = (dm_req_i && m_streak < int'(DSTREAK)) ? 2'd2 : (if_req_i ? 2'd1 : 2'd2);
                chk("mem_req", 32'(mem_req_o), 32'(m_pick != 2'd0));
                if (m_pick == 2'd1) begin
                    chk("if_mem_addr", mem_addr_o, if_addr_i);
                    chk("if_mem_we", 32'(mem_we_o), 32'd0);
                    chk("if_mem_be", 32'(mem_be_o), 32'hF);
                end else if (m_pick == 2'd2) begin
                    chk("dm_mem_addr", mem_addr_o, dm_addr_i);
                    chk("dm_mem_we", 32'(mem_we_o), 32'(dm_we_i));
                    chk("dm_mem_be", 32'(mem_be_o), 32'(dm_be_i));
                    chk("dm_mem_wdata", mem_wdata_o, dm_wdata_i);
                end
                chk("if_gnt", 32'(if_gnt_o), 32'(m_pick == 2'd1 && mem_gnt_i));
                chk("dm_gnt", 32'(dm_gnt_o), 32'(m_pick == 2'd2 && mem_gnt_i));
                if (mem_gnt_i && m_pick != 2'd0) begin
                    if (m_pick == 2'd2 && if_req_i) m_streak = (m_streak < int'(DSTREAK)) ? m_streak + 1 : m_streak;
                    else m_streak = 0;
                    m_out = 1'b1; m_owner = m_pick; m_pick = 2'd0;
                end
            end
        end
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog expired");
    end

    initial begin : main
        logic [31:0] v;
        rst_n = 1'b0; if_req_i = 1'b0; if_addr_i = '0;
        dm_req_i = 1'b0; dm_we_i = 1'b0; dm_be_i = '0; dm_addr_i = '0; dm_wdata_i = '0;
        mem_gnt_i = 1'b0; mem_rvalid_i = 1'b0; mem_rdata_i = '0;
        for (int i = 0; i < 16; i++) begin
            v = $urandom; mm_mem[i] = v; ref_mem[i] = v;
        end
        mm_mem[4] = 32'h00A00513; ref_mem[4] = 32'h00A00513;

        // Reset then idle.
        do_reset();
        chk("rst_gnt", 32'({o_if_gnt, o_dm_gnt}), 32'd0);
        chk("rst_rvalid", 32'({o_if_rv, o_dm_rv}), 32'd0);
        chk("rst_mem_req", 32'(o_mreq), 32'd0);
        chk("rst_busy", 32'(o_busy), 32'd0);
        chk("rst_mem_addr", o_maddr, 32'd0);

        // Fetch only, immediate grant, one-cycle memory latency.
        if_todo.push_back(32'h10);
        cycle();
        chk("t2_if_gnt", 32'(o_if_gnt), 32'd1);
        chk("t2_mem_addr", o_maddr, 32'h10);
        cycle();
        chk("t2_if_rvalid", 32'(o_if_rv), 32'd1);
        chk("t2_if_rdata", o_if_rd, 32'h00A00513);
        chk("t2_dm_rvalid", 32'(o_dm_rv), 32'd0);
        drain("t2_drain");

        // Collision: store wins, then the fetch; a reload checks the stored word.
        do_reset();
        if_todo.push_back(32'h8);
        dm_todo.push_back('{we: 1'b1, be: 4'hF, addr: 32'h4, wdata: 32'd120});
        run_until_log(2, 20, "t3_grants");
        if (g_log.size() >= 2) begin
            chk("t3_first_owner", 32'(g_log[0].own), 32'd2);
            chk("t3_first_we", 32'(g_log[0].we), 32'd1);
            chk("t3_first_wdata", g_log[0].wdata, 32'd120);
            chk("t3_second_owner", 32'(g_log[1].own), 32'd1);
        end
        dm_todo.push_back('{we: 1'b0, be: 4'hF, addr: 32'h4, wdata: 32'd0});
        drain("t3_drain");

        // Starvation: both held continuously.
        do_reset();
        for (int i = 0; i < 12; i++) begin
            if_todo.push_back(rand_addr());
            dm_todo.push_back('{we: 1'b0, be: 4'hF, addr: rand_addr(), wdata: 32'd0});
        end
        run_until_log(10, 100, "t4_grants");
        for (int i = 0; i < 10 && i < g_log.size(); i++)
            chk($sformatf("t4_owner_%0d", i), 32'(g_log[i].own), (i % 5 == 4) ? 32'd1 : 32'd2);
        if_todo.delete(); dm_todo.delete();
        drain("t4_drain");

        // Lock: fetch selected while memory stalls; data request arrives later.
        do_reset();
        mm_hold = 3;
        if_todo.push_back(32'h20);
        cycle();
        chk("t5_addr_c0", o_maddr, 32'h20);
        dm_todo.push_back('{we: 1'b0, be: 4'hF, addr: 32'h30, wdata: 32'd0});
        for (int c = 1; c < 3; c++) begin
            cycle();
            chk($sformatf("t5_addr_c%0d", c), o_maddr, 32'h20);
            chk($sformatf("t5_dm_gnt_c%0d", c), 32'(o_dm_gnt), 32'd0);
        end
        cycle();
        chk("t5_if_gnt", 32'(o_if_gnt), 32'd1);
        chk("t5_addr_gnt", o_maddr, 32'h20);
        run_until_log(2, 20, "t5_grants");
        if (g_log.size() >= 2) chk("t5_second_owner", 32'(g_log[1].own), 32'd2);
        drain("t5_drain");

        // Reset while a response is outstanding; late response is dropped.
        do_reset();
        k_lat_min = 5; k_lat_max = 5;
        if_todo.push_back(32'h10);
        cycle();
        cycle();
        chk("t6_busy_before", 32'(o_busy), 32'd1);
        do_reset();
        k_force_rv = 1'b1;
        cycle();
        chk("t6_if_rvalid", 32'(o_if_rv), 32'd0);
        chk("t6_dm_rvalid", 32'(o_dm_rv), 32'd0);
        chk("t6_busy", 32'(o_busy), 32'd0);
        chk("t6_mem_req", 32'(o_mreq), 32'd0);

        // Random traffic: moderate load, then heavy contention.
        do_reset();
        k_p_if = 50; k_p_dm = 60; k_p_gnt = 70; k_lat_min = 1; k_lat_max = 4;
        repeat (3000) cycle();
        drain("rand1_drain");
        k_p_if = 95; k_p_dm = 95; k_p_gnt = 50; k_lat_min = 1; k_lat_max = 2;
        repeat (1500) cycle();
        drain("rand2_drain");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_mem_port_arbiter

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one single-port unified memory between the IF stage (instruction fetch) and the MEM stage (load/store) of `riscv_pipeline_core`.
- Performs request arbitration and tracks one outstanding transaction.
- Routes each response back to the requester that issued it.
- Drives the grant/valid signals that the core's hazard logic turns into IF/MEM stalls.

Parameters:
- ADDR_W, 32, byte address width.
- DATA_W, 32, data width; byte-enable width is DATA_W/8.
- DSTREAK_MAX, 4, max consecutive data grants while a fetch is pending; must be ≥1.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  reset, synchronous, active-low.
- if_req_i  in  1  fetch request; held with if_addr_i stable until if_gnt_o.
- if_addr_i  in  ADDR_W  fetch address.
- if_gnt_o  out  1  fetch request accepted this cycle.
- if_rvalid_o  out  1  fetch data valid, one-cycle pulse.
- if_rdata_o  out  DATA_W  fetched instruction.
- dm_req_i  in  1  data request; held with all dm_* fields stable until dm_gnt_o.
- dm_we_i  in  1  1 = store.
- dm_be_i  in  DATA_W/8  store byte enables.
- dm_addr_i  in  ADDR_W  data address.
- dm_wdata_i  in  DATA_W  store data.
- dm_gnt_o  out  1  data request accepted.
- dm_rvalid_o  out  1  load data / store ack, one-cycle pulse.
- dm_rdata_o  out  DATA_W  load data; don't-care for stores.
- mem_req_o  out  1  request to memory.
- mem_we_o, mem_be_o, mem_addr_o, mem_wdata_o  out  1/DATA_W/8/ADDR_W/DATA_W  request fields to memory.
- mem_gnt_i  in  1  memory accepted the request.
- mem_rvalid_i  in  1  memory response valid.
- mem_rdata_i  in  DATA_W  memory read data.
- busy_o  out  1  a transaction is outstanding.

Behaviour:
- FSM states: ARB and WAIT_RESP. Registers:
  - owner (NONE/IF/DM)
  - lock_owner with lock_valid
  - dstreak counter, width clog2(DSTREAK_MAX+1)
- Reset (rst_n=0 at clk edge):
  - state=ARB, owner=NONE, lock_valid=0, dstreak=0.
  - All *_gnt_o, *_rvalid_o, mem_req_o and busy_o are 0.
  - rdata outputs and mem_* fields are 0.
- Selection in ARB, when no lock is held:
  - DM wins if dm_req_i and dstreak<DSTREAK_MAX.
  - Otherwise IF wins if if_req_i.
  - Otherwise DM wins if dm_req_i.
  - If a lock is held, the selection is lock_owner.
- ARB outputs:
  - mem_req_o=1 and mem_* fields are muxed from the selected requester, combinationally, in the same cycle.
  - mem_we_o=0 and mem_be_o=all-ones for IF.
- Grant:
  - The selected requester's *_gnt_o is combinationally equal to mem_gnt_i.
  - On grant: owner ← selected, state ← WAIT_RESP, lock_valid ← 0.
- No grant:
  - lock_owner ← selected, lock_valid ← 1.
  - The choice must not change until granted, even if the other requester has higher priority.
- dstreak update, applied on grant only:
  - DM granted while if_req_i=1: dstreak+1, saturating.
  - IF granted: dstreak ← 0.
  - DM granted with no fetch pending: dstreak ← 0.
- WAIT_RESP:
  - mem_req_o=0, busy_o=1, no grants issued.
  - On mem_rvalid_i: pulse owner's *_rvalid_o in the same cycle, with rdata = mem_rdata_i (combinational pass-through).
  - Then owner ← NONE, state ← ARB.
  - The next request can be issued the following cycle, so there are at least 2 cycles per transaction.
- Latency: grant in 0 cycles when memory grants immediately; response latency equals memory latency.
- mem_rvalid_i in ARB is illegal and ignored.
- rdata outputs of the non-owner are 0.
- Simultaneous if_req_i and dm_req_i with dstreak=0: DM granted.
- A requester dropping req before its grant is a protocol violation; lock behaviour is then undefined. Flag it with an assertion in the bench.
- Reset mid-transaction returns to ARB and drops the pending response. The core and memory are reset together.

Decomposition:
- Add to the shared `defines` package:
  - arb_state_e {ARB, WAIT_RESP}
  - mem_owner_e {OWN_NONE, OWN_IF, OWN_DM}
  - localparam DSTREAK_MAX_DEFAULT = 4
- Single module. The priority select is small enough to stay inline; no sub-module.

Test Plan:
1. Reset then idle: rst_n low 2 cycles → all grants, rvalids and mem_req_o are 0, busy_o=0.
2. Fetch only: if_req_i, addr 0x10, memory grants at once with 1-cycle latency, rdata 0x00A00513 → if_gnt_o cycle 0, if_rvalid_o cycle 1 with that data, dm_rvalid_o stays 0.
3. Collision: if_req_i and dm_req_i same cycle, store of 120 to addr 4 → DM granted first with mem_we_o=1 and wdata 120; IF granted on the next ARB cycle; responses are routed to the correct owners.
4. Starvation: dm_req_i and if_req_i continuously held → exactly 4 DM grants, then 1 IF grant, then dstreak restarts.
5. Lock: IF selected while mem_gnt_i=0 for 3 cycles, and dm_req_i rises in cycle 1 → mem_addr_o stays the IF address until the grant; DM is served afterwards.
6. Reset mid-operation: assert rst_n=0 in WAIT_RESP, then pulse mem_rvalid_i after release → no *_rvalid_o pulse, state ARB, busy_o=0.
